// File: rtl/threshold_mult_scheduler_pkg.sv
// threshold_mult_scheduler_pkg
// Shared types and constants for the threshold multiplier scheduler.
//   state_e  : scheduler FSM states (IDLE, ISSUE, WAIT, WRITE)
//   level_e  : decomposition level selector (L1 / L2)
//   THR_MAX  : saturation ceiling for the default 14-bit sample width
//   thrMaxFor: ceiling 2^(width-1)-1 for any sample width
package threshold_mult_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    typedef enum logic {
        LVL_L1 = 1'b0,
        LVL_L2 = 1'b1
    } level_e;

    localparam int unsigned DEF_ADC_WIDTH = 14;

    // Thresholds are compared against signed detail samples downstream,
    // so the largest usable value is the signed positive maximum.
    function automatic int unsigned thrMaxFor(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    localparam int unsigned THR_MAX = thrMaxFor(DEF_ADC_WIDTH);

endpackage

// File: rtl/threshold_mult_scheduler_if.sv
// threshold_mult_scheduler_if
// Bundles every non-clock/reset signal of the scheduler.
//   slave  modport: scheduler side (config, medians, constants, product in;
//                   multiplier operands, thresholds, status out)
//   master modport: environment side (the reverse directions)
interface threshold_mult_scheduler_if #(
    parameter int ADC_WIDTH   = 14,
    parameter int CONST_WIDTH = 5
);
    import threshold_mult_scheduler_pkg::*;

    logic [31:0]                      gpio_cfg;
    logic [ADC_WIDTH-1:0]             median_l1;
    logic [ADC_WIDTH-1:0]             median_l2;
    logic                             median_valid_l1;
    logic                             median_valid_l2;
    logic [CONST_WIDTH-1:0]           const_l1;
    logic [CONST_WIDTH-1:0]           const_l2;
    logic [ADC_WIDTH-1:0]             mult_a;
    logic [CONST_WIDTH-1:0]           mult_b;
    logic                             mult_start;
    logic [ADC_WIDTH+CONST_WIDTH-1:0] mult_p;
    logic [ADC_WIDTH-1:0]             thr_l1;
    logic [ADC_WIDTH-1:0]             thr_l2;
    logic                             thr_upd_l1;
    logic                             thr_upd_l2;
    logic                             busy;
    logic                             overrun;

    modport slave (
        input  gpio_cfg, median_l1, median_l2, median_valid_l1, median_valid_l2,
               const_l1, const_l2, mult_p,
        output mult_a, mult_b, mult_start, thr_l1, thr_l2, thr_upd_l1, thr_upd_l2,
               busy, overrun
    );

    modport master (
        output gpio_cfg, median_l1, median_l2, median_valid_l1, median_valid_l2,
               const_l1, const_l2, mult_p,
        input  mult_a, mult_b, mult_start, thr_l1, thr_l2, thr_upd_l1, thr_upd_l2,
               busy, overrun
    );

endinterface

// File: rtl/threshold_mult_scheduler_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter.
//   clk, rst      : clock, synchronous active-high reset
//   i_reqL1/L2    : request (pending) flags per level
//   i_accept      : the current grant is being consumed this cycle
//   o_grant       : level granted this cycle
//   o_valid       : at least one request is present
//   o_lastServed  : level most recently accepted (L2 after reset)
module rr_arb2
    import threshold_mult_scheduler_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_reqL1,
    input  logic   i_reqL2,
    input  logic   i_accept,
    output level_e o_grant,
    output logic   o_valid,
    output level_e o_lastServed
);

    level_e r_last;

    // With both levels requesting, the one not served last wins; starting
    // from L2 after reset means L1 gets the first grant.
    always_comb begin
        o_grant = LVL_L1;
        if (i_reqL1 && i_reqL2) begin
            if (r_last == LVL_L1) begin
                o_grant = LVL_L2;
            end
        end else if (i_reqL2) begin
            o_grant = LVL_L2;
        end
    end

    assign o_valid      = i_reqL1 | i_reqL2;
    assign o_lastServed = r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= LVL_L2;
        end else if (i_accept && o_valid) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/threshold_mult_scheduler.sv
// threshold_mult_scheduler
// Time-shares one external multiplier between two wavelet levels to form
// thr = min(median * const, THR_MAX) per level.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave view of threshold_mult_scheduler_if
//              gpio_cfg[31] enable; median/const/valid per level in;
//              mult_a/mult_b/mult_start out, mult_p in (MULT_LAT cycles later);
//              thr_l1/thr_l2 with update pulses, busy and sticky overrun out
module threshold_mult_scheduler
    import threshold_mult_scheduler_pkg::*;
#(
    parameter int ADC_WIDTH   = 14,
    parameter int CONST_WIDTH = 5,
    parameter int MULT_LAT    = 2
)(
    input logic                       clk,
    input logic                       rst,
    threshold_mult_scheduler_if.slave bus
);

    localparam int               PW        = ADC_WIDTH + CONST_WIDTH;
    localparam logic [PW-1:0]    THR_LIMIT = PW'(thrMaxFor(ADC_WIDTH));
    localparam logic [2:0]       WAIT_LAST = 3'(MULT_LAT - 1);

    state_e                 r_state;
    logic [2:0]             r_cnt;
    logic                   r_pendL1;
    logic                   r_pendL2;
    logic [ADC_WIDTH-1:0]   r_shMedL1;
    logic [ADC_WIDTH-1:0]   r_shMedL2;
    logic [CONST_WIDTH-1:0] r_shConstL1;
    logic [CONST_WIDTH-1:0] r_shConstL2;
    logic [ADC_WIDTH-1:0]   r_multA;
    logic [CONST_WIDTH-1:0] r_multB;
    logic [ADC_WIDTH-1:0]   r_thrL1;
    logic [ADC_WIDTH-1:0]   r_thrL2;
    logic                   r_updL1;
    logic                   r_updL2;
    logic                   r_overrun;

    logic                   w_en;
    logic                   w_unusedCfg;
    logic                   w_issue;
    level_e                 w_grant;
    logic                   w_grantValid;
    level_e                 w_lastServed;
    logic [ADC_WIDTH-1:0]   w_selMed;
    logic [CONST_WIDTH-1:0] w_selConst;
    logic [ADC_WIDTH-1:0]   w_sat;
    logic                   w_ovrL1;
    logic                   w_ovrL2;

    assign w_en        = bus.gpio_cfg[31];
    assign w_unusedCfg = ^bus.gpio_cfg[30:0];
    assign w_issue     = (r_state == ST_ISSUE);

    rr_arb2 u_arb (
        .clk          (clk),
        .rst          (rst),
        .i_reqL1      (r_pendL1),
        .i_reqL2      (r_pendL2),
        .i_accept     (w_issue),
        .o_grant      (w_grant),
        .o_valid      (w_grantValid),
        .o_lastServed (w_lastServed)
    );

    // Operands come straight from the granted shadow registers during ISSUE
    // and are frozen in r_multA/r_multB afterwards, so a new median landing
    // in the shadow mid-job cannot disturb the multiplier inputs.
    always_comb begin
        w_selMed   = r_shMedL1;
        w_selConst = r_shConstL1;
        if (w_grant == LVL_L2) begin
            w_selMed   = r_shMedL2;
            w_selConst = r_shConstL2;
        end
    end

    assign w_sat = (bus.mult_p > THR_LIMIT) ? THR_LIMIT[ADC_WIDTH-1:0]
                                            : bus.mult_p[ADC_WIDTH-1:0];

    // A repeat request only counts as an overrun when the earlier one is
    // still waiting; the level being issued right now has already been taken.
    assign w_ovrL1 = bus.median_valid_l1 && r_pendL1 && !(w_issue && w_grant == LVL_L1);
    assign w_ovrL2 = bus.median_valid_l2 && r_pendL2 && !(w_issue && w_grant == LVL_L2);

    // Shadow capture and pending flags; a fresh valid wins over the clear
    // performed when its level is issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pendL1    <= 1'b0;
            r_pendL2    <= 1'b0;
            r_shMedL1   <= '0;
            r_shMedL2   <= '0;
            r_shConstL1 <= '0;
            r_shConstL2 <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_issue && w_grant == LVL_L1) r_pendL1 <= 1'b0;
            if (w_issue && w_grant == LVL_L2) r_pendL2 <= 1'b0;
            if (bus.median_valid_l1) begin
                r_shMedL1   <= bus.median_l1;
                r_shConstL1 <= bus.const_l1;
                r_pendL1    <= 1'b1;
            end
            if (bus.median_valid_l2) begin
                r_shMedL2   <= bus.median_l2;
                r_shConstL2 <= bus.const_l2;
                r_pendL2    <= 1'b1;
            end
            if (w_ovrL1 || w_ovrL2) r_overrun <= 1'b1;
        end
    end

    // Job sequencer. The arbiter's last-served level is the level in flight
    // from the cycle after ISSUE until WRITE, so WRITE uses it to route the
    // product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_multA <= '0;
            r_multB <= '0;
            r_thrL1 <= '0;
            r_thrL2 <= '0;
            r_updL1 <= 1'b0;
            r_updL2 <= 1'b0;
        end else begin
            r_updL1 <= 1'b0;
            r_updL2 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_en && w_grantValid) r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_multA <= w_selMed;
                    r_multB <= w_selConst;
                    r_cnt   <= 3'd1;
                    if (MULT_LAT == 1) r_state <= ST_WRITE;
                    else               r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == WAIT_LAST) r_state <= ST_WRITE;
                    else                    r_cnt   <= r_cnt + 3'd1;
                end
                ST_WRITE: begin
                    if (w_lastServed == LVL_L1) begin
                        r_thrL1 <= w_sat;
                        r_updL1 <= 1'b1;
                    end else begin
                        r_thrL2 <= w_sat;
                        r_updL2 <= 1'b1;
                    end
                    if (w_en && w_grantValid) r_state <= ST_ISSUE;
                    else                      r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mult_a     = w_issue ? w_selMed : r_multA;
    assign bus.mult_b     = w_issue ? w_selConst : r_multB;
    assign bus.mult_start = w_issue;
    assign bus.thr_l1     = r_thrL1;
    assign bus.thr_l2     = r_thrL2;
    assign bus.thr_upd_l1 = r_updL1;
    assign bus.thr_upd_l2 = r_updL2;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.overrun    = r_overrun;

endmodule
